// File: rtl/ff_fifo_pkg.sv
// Shared helpers for the flip-flop FIFO: width function, parameter legality, op encoding.
// Used by ff_fifo_any_depth (optional bypass via FF_FIFO_BYPASS_EN) and ff_fifo_ptr.
package ff_fifo_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = (value > 0) ? value - 1 : 0; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit params_legal(input int depth, input int af_level, input int ae_level);
        return (depth >= 2) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/ff_fifo_ptr.sv
// Modulo-DEPTH pointer counter with enable and synchronous active-high reset.
// Wraps from DEPTH-1 to 0, so DEPTH need not be a power of two.
module ff_fifo_ptr
    import ff_fifo_pkg::*;
#(
    parameter int DEPTH   = 5,
    parameter int P_WIDTH = clog2_f(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    output logic [P_WIDTH-1:0] ptr_o
);

    localparam logic [P_WIDTH-1:0] LAST = P_WIDTH'(DEPTH - 1);

    logic [P_WIDTH-1:0] ptr_q;
    logic [P_WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ff_fifo_any_depth.sv
// Flip-flop FIFO of arbitrary depth with level and almost-full/empty flags.
// Define FF_FIFO_BYPASS_EN to let a word pass combinationally through an empty FIFO.
module ff_fifo_any_depth
    import ff_fifo_pkg::*;
#(
    parameter int D_WIDTH  = 6,
    parameter int DEPTH    = 5,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int L_WIDTH = clog2_f(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [L_WIDTH-1:0] level,
    output logic               almost_full,
    output logic               almost_empty
);

    localparam int P_WIDTH = clog2_f(DEPTH);
    localparam logic [L_WIDTH-1:0] FULL_LVL = L_WIDTH'(DEPTH);
    localparam logic [L_WIDTH-1:0] AF_LVL   = L_WIDTH'(AF_LEVEL);
    localparam logic [L_WIDTH-1:0] AE_LVL   = L_WIDTH'(AE_LEVEL);

    if (!params_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
        $error("ff_fifo_any_depth: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [P_WIDTH-1:0] wr_ptr;
    logic [P_WIDTH-1:0] rd_ptr;
    logic [L_WIDTH-1:0] level_q;
    logic [L_WIDTH-1:0] level_d;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    fifo_op_e           op;

    assign empty    = (level_q == '0);
    assign full     = (level_q == FULL_LVL);
    assign up_ready = !rst && !full;

`ifdef FF_FIFO_BYPASS_EN
    logic bypass;
    // A pass-through word is never stored; a stalled one is written as usual.
    assign bypass     = !rst && empty && up_valid;
    assign down_valid = !rst && (!empty || up_valid);
    assign down_data  = bypass ? up_data : mem_q[rd_ptr];
    assign push       = up_valid && up_ready && !(bypass && down_ready);
`else
    assign down_valid = !rst && !empty;
    assign down_data  = mem_q[rd_ptr];
    assign push       = up_valid && up_ready;
`endif

    assign pop = down_valid && down_ready && !empty;

    always_comb begin
        op      = fifo_op_e'({push, pop});
        level_d = level_q;
        unique case (op)
            OP_PUSH: level_d = level_q + 1'b1;
            OP_POP:  level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= up_data;
        end
    end

    ff_fifo_ptr #(.DEPTH(DEPTH), .P_WIDTH(P_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (push),
        .ptr_o (wr_ptr)
    );

    ff_fifo_ptr #(.DEPTH(DEPTH), .P_WIDTH(P_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pop),
        .ptr_o (rd_ptr)
    );

    // Flags come from the level register only, forced to reset values while rst is high.
    assign level        = rst ? '0 : level_q;
    assign almost_full  = !rst && (level_q >= AF_LVL);
    assign almost_empty = rst || (level_q <= AE_LVL);

endmodule

// File: tb/tb_ff_fifo_any_depth.sv
// Directed bench for ff_fifo_any_depth (DEPTH=5, AF=4, AE=1); honours FF_FIFO_BYPASS_EN.
module tb_ff_fifo_any_depth;

`ifdef FF_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic [5:0] down_data;
    logic       down_valid;
    logic       down_ready;
    logic [2:0] level;
    logic       almost_full;
    logic       almost_empty;

    int n_checks = 0;
    int n_pass   = 0;

    ff_fifo_any_depth #(.D_WIDTH(6), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_data      (up_data),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .down_data    (down_data),
        .down_valid   (down_valid),
        .down_ready   (down_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       uv;
        logic [5:0] ud;
        logic       dr;
        logic       ur;
        logic       dv;
        logic       chk_d;
        logic [5:0] dd;
        logic [2:0] lvl;
        logic       af;
        logic       ae;
    } vec_t;

    vec_t vecs [16];
    logic [5:0] q [$];

    function automatic vec_t mk(int r, int uv, int ud, int dr, int ur, int dv,
                                int chk, int dd, int lvl, int af, int ae);
        vec_t v;
        v.rst = (r != 0);   v.uv = (uv != 0);  v.ud = 6'(ud);  v.dr = (dr != 0);
        v.ur = (ur != 0);   v.dv = (dv != 0);  v.chk_d = (chk != 0);
        v.dd = 6'(dd);      v.lvl = 3'(lvl);   v.af = (af != 0); v.ae = (ae != 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input int r, input int uv, input int ud, input int dr);
        @(negedge clk);
        rst        = (r != 0);
        up_valid   = (uv != 0);
        up_data    = 6'(ud);
        down_ready = (dr != 0);
        #1;
    endtask

    // Reference queue model: checks the cycle's outputs, then applies the handshakes.
    task automatic sb_step(input string tag);
        int   sz;
        logic exp_dv;
        sz     = q.size();
        exp_dv = (sz != 0) || (BYP && up_valid);
        check({tag, ".level"}, 32'(level), 32'(sz));
        check({tag, ".up_ready"}, 32'(up_ready), 32'(sz != 5));
        check({tag, ".down_valid"}, 32'(down_valid), 32'(exp_dv));
        if (exp_dv && down_ready) begin
            check({tag, ".down_data"}, 32'(down_data), 32'((sz != 0) ? q[0] : up_data));
        end
        if (up_valid && (sz != 5) && !(BYP && (sz == 0) && down_ready)) begin
            q.push_back(up_data);
        end
        if (exp_dv && down_ready && (sz != 0)) begin
            void'(q.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_dv;
        rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;

        //            rst uv  ud  dr  ur dv chk dd lvl af ae
        vecs[0]  = mk(1, 1, 'h11, 1,  0, 0, 0,  0, 0, 0, 1);
        vecs[1]  = mk(0, 0,   0,  0,  1, 0, 0,  0, 0, 0, 1);
        vecs[2]  = mk(0, 1,   1,  0,  1, 0, 0,  0, 0, 0, 1);
        vecs[3]  = mk(0, 1,   2,  0,  1, 1, 1,  1, 1, 0, 1);
        vecs[4]  = mk(0, 1,   3,  0,  1, 1, 1,  1, 2, 0, 0);
        vecs[5]  = mk(0, 1,   4,  0,  1, 1, 1,  1, 3, 0, 0);
        vecs[6]  = mk(0, 1,   5,  0,  1, 1, 1,  1, 4, 1, 0);
        vecs[7]  = mk(0, 1,   6,  0,  0, 1, 1,  1, 5, 1, 0);
        vecs[8]  = mk(0, 1,   7,  1,  0, 1, 1,  1, 5, 1, 0);
        vecs[9]  = mk(0, 0,   0,  0,  1, 1, 1,  2, 4, 1, 0);
        vecs[10] = mk(0, 0,   0,  1,  1, 1, 1,  2, 4, 1, 0);
        vecs[11] = mk(0, 0,   0,  1,  1, 1, 1,  3, 3, 0, 0);
        vecs[12] = mk(0, 1,   8,  1,  1, 1, 1,  4, 2, 0, 0);
        vecs[13] = mk(0, 0,   0,  1,  1, 1, 1,  5, 2, 0, 0);
        vecs[14] = mk(0, 0,   0,  1,  1, 1, 1,  8, 1, 0, 1);
        vecs[15] = mk(0, 0,   0,  0,  1, 0, 0,  0, 0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            drive(int'(vecs[i].rst), int'(vecs[i].uv), int'(vecs[i].ud), int'(vecs[i].dr));
            exp_dv = vecs[i].dv | (BYP & vecs[i].uv & !vecs[i].rst & (vecs[i].lvl == 3'd0));
            check($sformatf("v%0d.up_ready", i), 32'(up_ready), 32'(vecs[i].ur));
            check($sformatf("v%0d.down_valid", i), 32'(down_valid), 32'(exp_dv));
            check($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].lvl));
            check($sformatf("v%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].af));
            check($sformatf("v%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
            if (vecs[i].chk_d) begin
                check($sformatf("v%0d.down_data", i), 32'(down_data), 32'(vecs[i].dd));
            end
        end

        // Streaming 0..11 through the FIFO, pointers wrap several times.
        q.delete();
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, i, 1);
            sb_step($sformatf("stream%0d", i));
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1);
            sb_step($sformatf("drain%0d", k));
        end

        // Push into empty FIFO with consumer ready.
        drive(0, 1, 'h2A, 1);
`ifdef FF_FIFO_BYPASS_EN
        check("byp.down_valid", 32'(down_valid), 32'd1);
        check("byp.down_data", 32'(down_data), 32'h2A);
        check("byp.level", 32'(level), 32'd0);
        drive(0, 0, 0, 1);
        check("byp.next_valid", 32'(down_valid), 32'd0);
        check("byp.next_level", 32'(level), 32'd0);
`else
        check("lat.down_valid0", 32'(down_valid), 32'd0);
        check("lat.level0", 32'(level), 32'd0);
        drive(0, 0, 0, 1);
        check("lat.down_valid1", 32'(down_valid), 32'd1);
        check("lat.down_data1", 32'(down_data), 32'h2A);
        check("lat.level1", 32'(level), 32'd1);
        drive(0, 0, 0, 0);
        check("lat.level2", 32'(level), 32'd0);
        check("lat.down_valid2", 32'(down_valid), 32'd0);
`endif

        // Mid-stream reset at level 3 with handshakes active.
        drive(0, 1, 'h31, 0);
        drive(0, 1, 'h32, 0);
        drive(0, 1, 'h33, 0);
        drive(0, 0, 0, 0);
        check("rst.pre_level", 32'(level), 32'd3);
        drive(1, 1, 'h3F, 1);
        check("rst.level", 32'(level), 32'd0);
        check("rst.down_valid", 32'(down_valid), 32'd0);
        check("rst.up_ready", 32'(up_ready), 32'd0);
        check("rst.almost_full", 32'(almost_full), 32'd0);
        check("rst.almost_empty", 32'(almost_empty), 32'd1);
        drive(0, 0, 0, 0);
        check("rst.post_up_ready", 32'(up_ready), 32'd1);
        check("rst.post_down_valid", 32'(down_valid), 32'd0);
        check("rst.post_level", 32'(level), 32'd0);
        drive(0, 1, 'h3C, 0);
        drive(0, 0, 0, 0);
        check("rst.fresh_valid", 32'(down_valid), 32'd1);
        check("rst.fresh_data", 32'(down_data), 32'h3C);
        check("rst.fresh_level", 32'(level), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
